// File: rtl/instru_mem_pkg.sv
// Shared definitions for the byte-organised instruction memory loader.
package instru_mem_pkg;

  // Load controller states: empty, partially loaded, every byte written.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoading = 2'd1,
    StFull    = 2'd2
  } load_state_e;

  // Default instruction width and the matching number of bytes per fetched word.
  localparam int unsigned NB_INSTRUCTION_DEF = 32;
  localparam int unsigned BYTES_PER_WORD     = NB_INSTRUCTION_DEF / 8;

  // Read-error codes; bits can combine when a read is both misaligned and out of range.
  localparam logic [1:0] RdErrNone  = 2'b00;
  localparam logic [1:0] RdErrAlign = 2'b01;
  localparam logic [1:0] RdErrRange = 2'b10;

  function automatic int unsigned bytes_per_word(input int unsigned nb_instruction);
    return nb_instruction / 8;
  endfunction

endpackage

// File: rtl/instru_mem_byte_ram.sv
// Byte array with one synchronous write port and NumTaps consecutive read taps.
// Taps are combinational; the consumer registers them on the same edge a write
// lands, which gives read-first behaviour for a same-byte collision.
module instru_mem_byte_ram
  import instru_mem_pkg::*;
#(
  parameter int unsigned Width   = 8,
  parameter int unsigned Depth   = 64,
  parameter int unsigned NumTaps = BYTES_PER_WORD
) (
  input  logic                               clk_i,
  input  logic                               we_i,
  input  logic [$clog2(Depth)-1:0]           waddr_i,
  input  logic [Width-1:0]                   wdata_i,
  input  logic [$clog2(Depth)-1:0]           raddr_i,
  output logic [NumTaps-1:0][Width-1:0]      rdata_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];

  // Storage is intentionally not reset; contents survive a controller reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Consecutive bytes starting at raddr_i; wrap only matters for reads the top rejects.
  always_comb begin
    for (int i = 0; i < int'(NumTaps); i++) begin
      rdata_o[i] = mem[raddr_i + AddrW'(i)];
    end
  end

endmodule

// File: rtl/instru_mem_loader.sv
// Serially loaded byte memory feeding the fetch stage with assembled instruction words.
// Optional feature: define INSTRU_MEM_PARITY_EN to store an even-parity bit per byte
// and report mismatches on in-range reads through o_parity_error.
module instru_mem_loader
  import instru_mem_pkg::*;
#(
  parameter int unsigned MEMORY_WIDTH   = 8,
  parameter int unsigned MEMORY_DEPTH   = 64,
  parameter int unsigned NB_ADDR        = 32,
  parameter int unsigned NB_INSTRUCTION = NB_INSTRUCTION_DEF,
  parameter int unsigned BIG_ENDIAN     = 1,
  parameter int unsigned NB_CNT         = $clog2(MEMORY_DEPTH) + 1
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_read_enable,
  input  logic [NB_ADDR-1:0]        i_read_addr,
  output logic [NB_INSTRUCTION-1:0] o_read_data,
  output logic                      o_read_valid,
  output logic                      o_read_error,
  input  logic                      i_write_enable,
  input  logic [MEMORY_WIDTH-1:0]   i_write_data,
  input  logic                      i_load_clear,
  output logic [NB_CNT-1:0]         o_load_count,
  output logic                      o_load_full,
`ifdef INSTRU_MEM_PARITY_EN
  output logic                      o_parity_error,
`endif
  output logic                      o_load_overflow
);

  localparam int unsigned BPW = bytes_per_word(NB_INSTRUCTION);
  localparam int unsigned AW  = $clog2(MEMORY_DEPTH);
`ifdef INSTRU_MEM_PARITY_EN
  localparam int unsigned CellW = MEMORY_WIDTH + 1;
`else
  localparam int unsigned CellW = MEMORY_WIDTH;
`endif

  load_state_e               state_q;
  logic [NB_CNT-1:0]         count_q;
  logic                      overflow_q;
  logic                      write_accept;
  logic [CellW-1:0]          wr_cell;
  logic [BPW-1:0][CellW-1:0] taps;
  logic [NB_ADDR:0]          rd_end;
  logic [1:0]                rd_err_code;
  logic [NB_INSTRUCTION-1:0] word;
  logic [NB_INSTRUCTION-1:0] read_data_q;
  logic                      read_valid_q;
  logic                      read_error_q;
`ifdef INSTRU_MEM_PARITY_EN
  logic                      par_mismatch;
  logic                      parity_error_q;
`endif

  // Clear wins over a same-cycle write; writes while full are dropped.
  assign write_accept = i_write_enable && !i_load_clear && (state_q != StFull);

`ifdef INSTRU_MEM_PARITY_EN
  assign wr_cell = {^i_write_data, i_write_data};
`else
  assign wr_cell = i_write_data;
`endif

  instru_mem_byte_ram #(
    .Width   (CellW),
    .Depth   (MEMORY_DEPTH),
    .NumTaps (BPW)
  ) u_ram (
    .clk_i   (i_clock),
    .we_i    (write_accept),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i (wr_cell),
    .raddr_i (i_read_addr[AW-1:0]),
    .rdata_o (taps)
  );

  // Load controller: write pointer, saturation at MEMORY_DEPTH and sticky overflow.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (i_load_clear) begin
      state_q    <= StIdle;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (i_write_enable) begin
      if (state_q == StFull) begin
        overflow_q <= 1'b1;
      end else begin
        count_q <= count_q + NB_CNT'(1);
        state_q <= (count_q == NB_CNT'(MEMORY_DEPTH - 1)) ? StFull : StLoading;
      end
    end
  end

  assign o_load_count    = count_q;
  assign o_load_full     = (count_q == NB_CNT'(MEMORY_DEPTH));
  assign o_load_overflow = overflow_q;

  // Address checks on the full address width so high addresses never alias low bytes.
  always_comb begin
    rd_end      = {1'b0, i_read_addr} + (NB_ADDR + 1)'(BPW);
    rd_err_code = RdErrNone;
    if ((i_read_addr % NB_ADDR'(BPW)) != '0) begin
      rd_err_code = rd_err_code | RdErrAlign;
    end
    if (rd_end > (NB_ADDR + 1)'(MEMORY_DEPTH)) begin
      rd_err_code = rd_err_code | RdErrRange;
    end
  end

  // Word assembly: tap 0 is the lowest address, placed per BIG_ENDIAN.
  always_comb begin
    word = '0;
`ifdef INSTRU_MEM_PARITY_EN
    par_mismatch = 1'b0;
`endif
    for (int i = 0; i < int'(BPW); i++) begin
      if (BIG_ENDIAN != 0) begin
        word[(int'(BPW) - 1 - i) * int'(MEMORY_WIDTH) +: MEMORY_WIDTH] =
          taps[i][MEMORY_WIDTH-1:0];
      end else begin
        word[i * int'(MEMORY_WIDTH) +: MEMORY_WIDTH] = taps[i][MEMORY_WIDTH-1:0];
      end
`ifdef INSTRU_MEM_PARITY_EN
      par_mismatch = par_mismatch | (^taps[i]);
`endif
    end
  end

  // Registered read port; outputs hold when no read is requested.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      read_data_q    <= '0;
      read_valid_q   <= 1'b0;
      read_error_q   <= 1'b0;
`ifdef INSTRU_MEM_PARITY_EN
      parity_error_q <= 1'b0;
`endif
    end else if (i_read_enable) begin
      read_valid_q <= 1'b1;
      if (rd_err_code != RdErrNone) begin
        read_data_q    <= '0;
        read_error_q   <= 1'b1;
`ifdef INSTRU_MEM_PARITY_EN
        parity_error_q <= 1'b0;
`endif
      end else begin
        read_data_q    <= word;
        read_error_q   <= 1'b0;
`ifdef INSTRU_MEM_PARITY_EN
        parity_error_q <= par_mismatch;
`endif
      end
    end else begin
      read_valid_q <= 1'b0;
    end
  end

  assign o_read_data  = read_data_q;
  assign o_read_valid = read_valid_q;
  assign o_read_error = read_error_q;
`ifdef INSTRU_MEM_PARITY_EN
  assign o_parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_instru_mem_loader.sv
// Bench for instru_mem_loader: big- and little-endian instances share stimulus and are
// checked every cycle against a byte-array model, plus literal directed expectations.
module tb_instru_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ren = 1'b0;
  logic [31:0] raddr = '0;
  logic        wen = 1'b0;
  logic [7:0]  wd = '0;
  logic        clr = 1'b0;

  logic [31:0] be_data, le_data;
  logic        be_valid, le_valid, be_err, le_err;
  logic [6:0]  be_count, le_count;
  logic        be_full, le_full, be_ovf, le_ovf;
`ifdef INSTRU_MEM_PARITY_EN
  logic        be_perr, le_perr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instru_mem_loader #(.BIG_ENDIAN(1)) dut_be (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_read_enable   (ren),
    .i_read_addr     (raddr),
    .o_read_data     (be_data),
    .o_read_valid    (be_valid),
    .o_read_error    (be_err),
    .i_write_enable  (wen),
    .i_write_data    (wd),
    .i_load_clear    (clr),
    .o_load_count    (be_count),
    .o_load_full     (be_full),
`ifdef INSTRU_MEM_PARITY_EN
    .o_parity_error  (be_perr),
`endif
    .o_load_overflow (be_ovf)
  );

  instru_mem_loader #(.BIG_ENDIAN(0)) dut_le (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_read_enable   (ren),
    .i_read_addr     (raddr),
    .o_read_data     (le_data),
    .o_read_valid    (le_valid),
    .o_read_error    (le_err),
    .i_write_enable  (wen),
    .i_write_data    (wd),
    .i_load_clear    (clr),
    .o_load_count    (le_count),
    .o_load_full     (le_full),
`ifdef INSTRU_MEM_PARITY_EN
    .o_parity_error  (le_perr),
`endif
    .o_load_overflow (le_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [64];
  bit          m_known [64];
  bit          m_corrupt [64];
  int          m_count = 0;
  bit          m_ovf = 0, m_valid = 0, m_err = 0, m_dknown = 1, m_perr = 0;
  logic [31:0] m_be = '0, m_le = '0;
  longint      ma;
  int          idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count = 0; m_ovf = 0; m_valid = 0; m_err = 0;
      m_be = '0; m_le = '0; m_dknown = 1; m_perr = 0;
    end else begin
      // Read sees memory contents from before this edge's write.
      if (ren) begin
        m_valid = 1;
        ma = longint'({32'h0, raddr});
        m_be = '0; m_le = '0; m_dknown = 1; m_perr = 0;
        if ((ma % 4) != 0 || ma + 4 > 64) begin
          m_err = 1;
        end else begin
          m_err = 0;
          for (int k = 0; k < 4; k++) begin
            idx = int'(ma) + k;
            m_be = {m_be[23:0], m_mem[idx]};
            m_le[8*k +: 8] = m_mem[idx];
            if (!m_known[idx]) m_dknown = 0;
            if (m_corrupt[idx]) m_perr = 1;
          end
        end
      end else begin
        m_valid = 0;
      end
      if (clr) begin
        m_count = 0; m_ovf = 0;
      end else if (wen) begin
        if (m_count == 64) m_ovf = 1;
        else begin
          m_mem[m_count] = wd; m_known[m_count] = 1; m_corrupt[m_count] = 0;
          m_count++;
        end
      end
    end
  end

  // Compare process: every output of both instances, every cycle.
  always @(negedge clk) begin
    check("be_valid", 32'(be_valid), 32'(m_valid));
    check("le_valid", 32'(le_valid), 32'(m_valid));
    check("be_error", 32'(be_err), 32'(m_err));
    check("le_error", 32'(le_err), 32'(m_err));
    check("be_count", 32'(be_count), 32'(m_count));
    check("le_count", 32'(le_count), 32'(m_count));
    check("be_full", 32'(be_full), 32'(m_count == 64));
    check("le_full", 32'(le_full), 32'(m_count == 64));
    check("be_overflow", 32'(be_ovf), 32'(m_ovf));
    check("le_overflow", 32'(le_ovf), 32'(m_ovf));
    if (m_dknown) begin
      check("be_data", be_data, m_be);
      check("le_data", le_data, m_le);
`ifdef INSTRU_MEM_PARITY_EN
      check("be_parity", 32'(be_perr), 32'(m_perr));
      check("le_parity", 32'(le_perr), 32'(m_perr));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wen = 1'b1; wd = b; cyc(); wen = 1'b0;
  endtask

  task automatic read(input logic [31:0] a);
    ren = 1'b1; raddr = a; cyc(); ren = 1'b0;
  endtask

  logic [7:0] b0;
  int         r;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_count", 32'(be_count), 32'd0);
    check("rst_valid", 32'(be_valid), 32'd0);
    check("rst_data", be_data, 32'd0);
    check("rst_flags", {29'd0, be_err, be_full, be_ovf}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Basic load and both endiannesses.
    for (int k = 0; k < 8; k++) write_byte(8'((k + 1) * 8'h11));
    check("load8_count", 32'(be_count), 32'd8);
    read(32'd0);
    check("rd0_valid", 32'(be_valid), 32'd1);
    check("rd0_be", be_data, 32'h11223344);
    check("rd0_le", le_data, 32'h44332211);
    check("model_rd0_be", m_be, 32'h11223344);
    read(32'd4);
    check("rd4_be", be_data, 32'h55667788);
    check("rd4_le", le_data, 32'h88776655);
    read(32'd2);
    check("rd2_err", {be_err, be_data[30:0]}, 32'h8000_0000);
    check("rd2_data", be_data, 32'd0);
    read(32'd64);
    check("rd64_err", 32'(be_err), 32'd1);
    check("rd64_data", be_data, 32'd0);
    read(32'hFFFF_FFFC);
    check("rdhigh_err", 32'(be_err), 32'd1);
    read(32'd4);
    check("rd4b_err", 32'(be_err), 32'd0);
    check("rd4b_be", be_data, 32'h55667788);
    cyc();
    check("idle_valid", 32'(be_valid), 32'd0);
    check("idle_hold", be_data, 32'h55667788);

    // Asynchronous reset mid-load.
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int k = 0; k < 5; k++) write_byte(8'(8'hA0 + k));
    check("mid_count", 32'(be_count), 32'd5);
    read(32'd0);
    check("mid_rd_be", be_data, 32'hA0A1A2A3);
    rst_n = 1'b0;
    #1;
    check("async_count", 32'(be_count), 32'd0);
    check("async_valid", 32'(be_valid), 32'd0);
    check("async_data", be_data, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int k = 0; k < 4; k++) write_byte(8'(8'hB1 + k));
    read(32'd0);
    check("reload_be", be_data, 32'hB1B2B3B4);
    read(32'd4);
    check("keep_be", be_data, 32'hA4667788);

    // Fill to saturation, overflow, then clear racing a write.
    clr = 1'b1; cyc(); clr = 1'b0;
    b0 = 8'($urandom);
    for (int k = 0; k < 64; k++) write_byte(k == 0 ? b0 : 8'($urandom));
    check("fill_full", 32'(be_full), 32'd1);
    check("fill_count", 32'(be_count), 32'd64);
    check("fill_ovf_pre", 32'(be_ovf), 32'd0);
    write_byte(8'h5A);
    check("ovf_set", 32'(be_ovf), 32'd1);
    check("ovf_count", 32'(be_count), 32'd64);
    read(32'd0);
    check("ovf_byte0", 32'(be_data[31:24]), 32'(b0));
    read(32'd60);
    check("rd60_err", 32'(be_err), 32'd0);
    clr = 1'b1; wen = 1'b1; wd = ~b0; cyc(); clr = 1'b0; wen = 1'b0;
    check("clr_count", 32'(be_count), 32'd0);
    check("clr_flags", {30'd0, be_full, be_ovf}, 32'd0);
    read(32'd0);
    check("clr_dropped", 32'(be_data[31:24]), 32'(b0));

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      ren = 1'($urandom);
      r = int'($urandom_range(0, 9));
      if (r <= 5)      raddr = 32'($urandom_range(0, 15)) * 4;
      else if (r == 6) raddr = 32'($urandom_range(0, 63));
      else if (r == 7) raddr = 32'd64 + 32'($urandom_range(0, 7)) * 4;
      else if (r == 8) raddr = 32'hFFFF_FFFC;
      else             raddr = $urandom;
      wen = ($urandom_range(0, 3) != 0);
      wd  = 8'($urandom);
      clr = ($urandom_range(0, 39) == 0);
      cyc();
    end
    ren = 1'b0; wen = 1'b0; clr = 1'b0;
    cyc();

`ifdef INSTRU_MEM_PARITY_EN
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int k = 0; k < 8; k++) write_byte(8'((k + 1) * 8'h11));
    dut_be.u_ram.mem[1][8] = ~dut_be.u_ram.mem[1][8];
    dut_le.u_ram.mem[1][8] = ~dut_le.u_ram.mem[1][8];
    m_corrupt[1] = 1;
    read(32'd0);
    check("par_flip", 32'(be_perr), 32'd1);
    read(32'd4);
    check("par_clean", 32'(be_perr), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instru_mem_loader.md
Name: instru_mem_loader

Overview:
- Parametrised successor of the byte-organised instruction memory.
- Byte-wide storage, loaded serially by the debug unit through an auto-incrementing write pointer.
- Assembles NB_INSTRUCTION-bit words for the IF stage with selectable endianness, alignment/range checking and load-progress flags.
- Sits between the debug unit (loader side) and the fetch stage (read side).

Parameters:
- MEMORY_WIDTH, 8: bits per stored byte; fixed at 8, width rules assume it.
- MEMORY_DEPTH, 64: number of bytes; power of two, at least NB_INSTRUCTION/8.
- NB_ADDR, 32: read address width (byte address).
- NB_INSTRUCTION, 32: word width; multiple of 8.
- BIG_ENDIAN, 1: 1 = byte at lowest address drives the MSBs; 0 = it drives the LSBs.
- NB_CNT, $clog2(MEMORY_DEPTH)+1: load counter width.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_read_enable  in  1  fetch request.
- i_read_addr  in  NB_ADDR  byte address of the word.
- o_read_data  out  NB_INSTRUCTION  assembled word.
- o_read_valid  out  1  o_read_data updated this cycle.
- o_read_error  out  1  last read was misaligned or out of range.
- i_write_enable  in  1  debug byte strobe.
- i_write_data  in  MEMORY_WIDTH  debug byte.
- i_load_clear  in  1  rewind write pointer, clear flags.
- o_load_count  out  NB_CNT  bytes written since last clear/reset.
- o_load_full  out  1  o_load_count == MEMORY_DEPTH.
- o_load_overflow  out  1  sticky: write attempted while full.

Behaviour:
- Reset (i_reset low, asynchronous assert, synchronous release):
  - o_read_data = 0, o_read_valid = 0, o_read_error = 0.
  - o_load_count = 0, o_load_full = 0, o_load_overflow = 0.
  - Byte array is not reset.
  - Reset mid-load rewinds the pointer to 0; already written bytes keep their values.
- Load path, one byte per cycle:
  - Write accepted when i_write_enable = 1 and not full: mem[count] <= i_write_data, count +1.
  - o_load_full is combinational from count.
  - Write while full: byte dropped, count unchanged, o_load_overflow set.
  - i_load_clear = 1: count, o_load_full and o_load_overflow cleared next edge. Clear has priority over a same-cycle write (byte dropped).
  - No wrap-around: the pointer saturates at MEMORY_DEPTH.
- Read path, 1-cycle latency, registered:
  - Edge with i_read_enable = 1: o_read_valid = 1 next cycle. i_read_enable = 0: o_read_valid = 0 and o_read_data/o_read_error hold.
  - Error when i_read_addr mod (NB_INSTRUCTION/8) != 0, or i_read_addr + NB_INSTRUCTION/8 > MEMORY_DEPTH. Then o_read_data = 0, o_read_error = 1, o_read_valid = 1.
  - Otherwise o_read_error = 0 and word bytes come from mem[addr .. addr+NB_INSTRUCTION/8-1], ordered per BIG_ENDIAN.
  - Read and write to the same byte on the same edge: read-first, returns the old byte.
  - Address compare uses the full NB_ADDR width; no truncation aliasing.
- Internal state machine (load controller):
  - States: IDLE (count 0), LOADING (0 < count < DEPTH), FULL.
  - IDLE→LOADING on first accepted write; LOADING→FULL on the write that makes count == DEPTH.
  - Any→IDLE on i_load_clear or reset.

Optional Feature:
- Macro: INSTRU_MEM_PARITY_EN.
- Defined:
  - Each stored byte carries an even-parity bit computed at write.
  - On a valid, in-range read, extra output o_parity_error (1 bit, reset 0, same timing as o_read_data) = OR of per-byte parity mismatches.
  - Parity bits of never-written bytes are X in simulation; the bench only reads loaded bytes.
- Undefined: no parity storage, no o_parity_error port.

Decomposition:
- Shared package instru_mem_pkg:
  - load-state enum (IDLE/LOADING/FULL).
  - BYTES_PER_WORD = NB_INSTRUCTION/8.
  - read-error code constants.
- One natural sub-module: instru_mem_byte_ram, a byte array with one synchronous write port and BYTES_PER_WORD read-first read taps. It is instantiated once; the top holds the load FSM, checks and endian assembly.

Test Plan:
- Load 0x11,0x22,…,0x88 (8 bytes), read addr 0 and 4, BIG_ENDIAN = 1 → 0x11223344, then 0x55667788, o_read_valid = 1 one cycle after each request, o_load_count = 8.
- Same load with BIG_ENDIAN = 0, read addr 0 → 0x44332211.
- Read addr 2 → o_read_data = 0, o_read_error = 1. Read addr 64 → same. Then read addr 4 → error clears, 0x55667788.
- Write 64 bytes, then 1 more → o_load_full = 1, o_load_overflow = 1, count = 64, byte 0 unchanged. Assert i_load_clear together with a write → count = 0, flags 0, byte dropped.
- Pulse i_reset low mid-load at count = 5 → outputs 0 immediately (asynchronous). Reload from 0 overwrites bytes 0–3; read addr 0 returns the new word.
- INSTRU_MEM_PARITY_EN: force a parity bit flip via hierarchical access on byte 1, read addr 0 → o_parity_error = 1; clean word → 0.
